// File: rtl/payload_seq_pkg.sv
// payload_seq_pkg
// Shared definitions for the payload engine packet sequencer:
//   state_t      - sequencer FSM encoding (binary, 5 states)
//   NUM_ENG_DEF  - default number of engine match lines
//   DRAIN_DEF    - default number of post-packet drain cycles
//   LEN_W        - width of the packet length counter / m_len
//   len_sat_inc  - saturating increment used by the length counter
package payload_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    localparam int NUM_ENG_DEF = 32;
    localparam int DRAIN_DEF   = 2;
    localparam int LEN_W       = 16;

    function automatic logic [LEN_W-1:0] len_sat_inc(input logic [LEN_W-1:0] v);
        return (v == '1) ? v : v + LEN_W'(1);
    endfunction

endpackage

// File: rtl/payload_engine_seq_if.sv
// payload_engine_seq_if
// Byte-stream input channel and match-record output channel of the
// payload engine sequencer.
//   s_valid/s_ready/s_data/s_sop/s_eop        - framed byte stream in
//   m_valid/m_ready/m_id/m_none/m_last/
//   m_trunc/m_len                             - match records out
// Modports:
//   slave  - the sequencer (consumes bytes, produces records)
//   master - the environment (produces bytes, consumes records)
interface payload_engine_seq_if #(
    parameter int NUM_ENG = payload_seq_pkg::NUM_ENG_DEF,
    parameter int ID_W    = $clog2(NUM_ENG),
    parameter int LEN_W   = payload_seq_pkg::LEN_W
);
    logic             s_valid;
    logic             s_ready;
    logic [7:0]       s_data;
    logic             s_sop;
    logic             s_eop;

    logic             m_valid;
    logic             m_ready;
    logic [ID_W-1:0]  m_id;
    logic             m_none;
    logic             m_last;
    logic             m_trunc;
    logic [LEN_W-1:0] m_len;

    modport slave (
        input  s_valid, s_data, s_sop, s_eop, m_ready,
        output s_ready, m_valid, m_id, m_none, m_last, m_trunc, m_len
    );

    modport master (
        output s_valid, s_data, s_sop, s_eop, m_ready,
        input  s_ready, m_valid, m_id, m_none, m_last, m_trunc, m_len
    );
endinterface

// File: rtl/payload_seq_ffs.sv
// payload_seq_ffs
// Combinational find-first-set over the pending match vector.
//   vec   in   N     vector to scan
//   idx   out  IW    index of the lowest set bit (0 when none set)
//   any   out  1     at least one bit set
//   multi out  1     more than one bit set
module payload_seq_ffs #(
    parameter int N  = 32,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          any,
    output logic          multi
);

    // Scan from the top so the lowest set bit is the last writer.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = IW'(i);
        end
    end

    assign any   = |vec;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(vec & (vec - N'(1)));

endmodule

// File: rtl/payload_engine_seq.sv
// payload_engine_seq
// Packet sequencer for the payload engine array. Clears the engines at the
// start of each packet, feeds one byte per cycle to the character decoder
// and engines, drains the engine pipeline after the last byte, snapshots the
// match vector and reports one record per matching engine.
//
// Ports:
//   clk          in   1        only clock
//   rst_n        in   1        synchronous active-low reset
//   bus          slave         byte stream in / match records out
//   eng_char     out  8        registered byte to the character decoder
//   eng_byte_vld out  1        decoder gate
//   eng_en       out  1        engine flop enable
//   eng_sod      out  1        engine clear, high throughout reset
//   eng_match    in   NUM_ENG  engine match lines
//   busy         out  1        FSM not idle
//
// Build option: PAYLOAD_SEQ_LEN_CNT_EN builds the saturating packet length
// counter reported on m_len; without it m_len is tied to 0.
//
// state  | meaning
// IDLE   | waiting for a sop byte; non-sop bytes are consumed and dropped
// CLEAR  | one-cycle engine clear (eng_sod), sop byte held off
// STREAM | one byte per cycle into the engines
// DRAIN  | pipeline flush, match vector snapshot on the final cycle
// REPORT | one record per pending match, lowest index first
module payload_engine_seq
    import payload_seq_pkg::*;
#(
    parameter int NUM_ENG = NUM_ENG_DEF,
    parameter int DRAIN   = DRAIN_DEF,
    parameter int ID_W    = $clog2(NUM_ENG)
) (
    input  logic               clk,
    input  logic               rst_n,
    payload_engine_seq_if.slave bus,
    output logic [7:0]         eng_char,
    output logic               eng_byte_vld,
    output logic               eng_en,
    output logic               eng_sod,
    input  logic [NUM_ENG-1:0] eng_match,
    output logic               busy
);

    localparam int DCW = $clog2(DRAIN + 1);

    state_t             state_q, state_d;
    logic [DCW-1:0]     drain_cnt_q;
    logic               first_q;
    logic               trunc_q;
    logic [NUM_ENG-1:0] pend_q;

    logic               s_ready_c;
    logic               accept;
    logic               trunc_set;
    logic               capture;
    logic               rec_pop;

    logic [ID_W-1:0]    ffs_idx;
    logic               ffs_any;
    logic               ffs_multi;
    logic               in_report;

    payload_seq_ffs #(
        .N  (NUM_ENG),
        .IW (ID_W)
    ) u_ffs (
        .vec   (pend_q),
        .idx   (ffs_idx),
        .any   (ffs_any),
        .multi (ffs_multi)
    );

    always_comb begin
        state_d   = state_q;
        s_ready_c = 1'b0;
        accept    = 1'b0;
        trunc_set = 1'b0;
        capture   = 1'b0;
        rec_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_ready_c = ~(bus.s_valid & bus.s_sop);
                if (bus.s_valid && bus.s_sop) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                // The packet's own sop byte is taken once; any later sop
                // belongs to the next packet and cuts this one short.
                s_ready_c = first_q | ~bus.s_sop;
                if (bus.s_valid && s_ready_c) begin
                    accept = 1'b1;
                    if (bus.s_eop) state_d = ST_DRAIN;
                end else if (bus.s_valid && bus.s_sop) begin
                    trunc_set = 1'b1;
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (bus.m_ready) begin
                    rec_pop = 1'b1;
                    if (!ffs_multi) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // DRAIN lasts DRAIN+1 state cycles: the first carries the last byte on
    // the registered engine outputs, the next DRAIN present eng_en alone,
    // and the snapshot is taken on the last of those.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            eng_sod      <= 1'b1;
            eng_char     <= '0;
            eng_byte_vld <= 1'b0;
            eng_en       <= 1'b0;
            drain_cnt_q  <= '0;
            first_q      <= 1'b0;
            trunc_q      <= 1'b0;
            pend_q       <= '0;
        end else begin
            state_q      <= state_d;
            eng_sod      <= (state_d == ST_CLEAR);
            eng_byte_vld <= accept;
            eng_en       <= accept | ((state_q == ST_DRAIN) && (drain_cnt_q != '0));
            if (accept) eng_char <= bus.s_data;

            if (state_q == ST_CLEAR)  first_q <= 1'b1;
            else if (accept)          first_q <= 1'b0;

            if (state_d == ST_DRAIN && state_q != ST_DRAIN)
                drain_cnt_q <= DCW'(DRAIN);
            else if (state_q == ST_DRAIN && drain_cnt_q != '0)
                drain_cnt_q <= drain_cnt_q - DCW'(1);

            if (state_q == ST_CLEAR) trunc_q <= 1'b0;
            else if (trunc_set)      trunc_q <= 1'b1;

            if (capture)      pend_q <= eng_match;
            else if (rec_pop) pend_q <= pend_q & (pend_q - NUM_ENG'(1));
        end
    end

`ifdef PAYLOAD_SEQ_LEN_CNT_EN
    logic [LEN_W-1:0] len_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            len_q <= '0;
        end else if (accept) begin
            len_q <= len_sat_inc(len_q);
        end
    end

    assign bus.m_len = in_report ? len_q : '0;
`else
    assign bus.m_len = '0;
`endif

    assign in_report   = (state_q == ST_REPORT);
    // State alone would present IDLE readiness while reset is still held.
    assign bus.s_ready = rst_n & s_ready_c;
    assign bus.m_valid = in_report;
    assign bus.m_id    = in_report ? ffs_idx : '0;
    assign bus.m_none  = in_report & ~ffs_any;
    assign bus.m_last  = in_report & ~ffs_multi;
    assign bus.m_trunc = in_report & trunc_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
